// File: rtl/blink_scheduler.sv
// blink_scheduler: time-shares one status LED among NREQ requesters.
// Each grant plays a blink code of N pulses (ON/OFF intervals, then a GAP),
// paced by a prescaled tick, and finishes with a one-cycle ack to the grantee.
module blink_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*CNT_W-1:0]     count,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      light
);

    localparam int unsigned IDW    = $clog2(NREQ);
    localparam int unsigned PW     = $clog2(TICK_DIV);
    localparam int unsigned MAXT_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAXT   = (MAXT_A > GAP_TICKS) ? MAXT_A : GAP_TICKS;
    localparam int unsigned TW     = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              light_q, light_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              found;
    logic [IDW-1:0]    gidx;
    logic [CNT_W-1:0]  gcount;

    // Round-robin search: first requester at or after the rr pointer.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((32'(rr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        gcount = count[gidx*CNT_W +: CNT_W];
    end

    // Next-state logic: prescaler, interval timer, pulse counter and outputs.
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        ack_d   = '0;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying ack is a mandatory idle cycle.
                if (ack_q == '0 && found) begin
                    grant_d = gidx;
                    rr_d    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                    rem_d   = gcount;
                    presc_d = '0;
                    timer_d = '0;
                    if (gcount == '0) begin
                        ack_d = NREQ'(1) << gidx;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (tick) begin
                    if (timer_q == TW'(ON_TICKS - 1)) begin
                        timer_d = '0;
                        rem_d   = rem_q - CNT_W'(1);
                        state_d = (rem_q > CNT_W'(1)) ? S_OFF : S_GAP;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (timer_q == TW'(OFF_TICKS - 1)) begin
                        timer_d = '0;
                        state_d = S_ON;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (timer_q == TW'(GAP_TICKS - 1)) begin
                        timer_d = '0;
                        state_d = S_IDLE;
                        ack_d   = NREQ'(1) << grant_q;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        light_d = (state_d == S_ON);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            timer_q <= '0;
            rem_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            light_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            light_q <= light_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign light    = light_q;

endmodule
